hilo_unit: RTL and testbench

//  Pipeline-facing HI/LO register unit for MULT/MULTU, MTHI/MTLO and MFHI/MFLO.

---
 rtl/hilo_pkg.sv | 23 ++
 rtl/hilo_unit.sv | 82 ++++++++
 tb/tb_hilo_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply unit: width, FSM states, MD funct codes.
// Decode and the hilo_unit datapath both import this package.
package hilo_pkg;

    localparam int HILO_W = 32;

    typedef enum logic [1:0] {
        HILO_IDLE = 2'd0,
        HILO_RUN  = 2'd1,
        HILO_FIX  = 2'd2
    } hilo_state_e;

    // SPECIAL-opcode funct field values for the multiply/divide group
    typedef enum logic [5:0] {
        MD_MFHI  = 6'h10,
        MD_MTHI  = 6'h11,
        MD_MFLO  = 6'h12,
        MD_MTLO  = 6'h13,
        MD_MULT  = 6'h18,
        MD_MULTU = 6'h19
    } md_funct_e;

endpackage

// File: rtl/hilo_unit.sv
// HI/LO register unit: feeds operand magnitudes to an external unsigned serial
// multiplier, sign-fixes its product into HI/LO and stalls dependent accesses.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int W = HILO_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           is_signed,
    input  logic [W-1:0]   op1,
    input  logic [W-1:0]   op2,
    input  logic           mthi,
    input  logic           mtlo,
    input  logic [W-1:0]   wdata,
    input  logic           rd_hi,
    input  logic           rd_lo,
    output logic [W-1:0]   rdata,
    output logic           stall,
    output logic           busy,
    output logic [W-1:0]   mult_op1,
    output logic [W-1:0]   mult_op2,
    output logic           mult_go,
    input  logic           mult_hold,
    input  logic [2*W-1:0] mult_res
);

    hilo_state_e    state;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [2*W-1:0] prod;
    logic           neg;

    assign busy  = (state != HILO_IDLE);
    assign stall = busy & (start | mthi | mtlo | rd_hi | rd_lo);
    // Reads see the register contents before any same-cycle MT write lands.
    assign rdata = rd_hi ? hi : lo;

    // NOTE: every register here is state, so it is assigned with <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HILO_IDLE;
            hi       <= '0;
            lo       <= '0;
            prod     <= '0;
            neg      <= 1'b0;
            mult_go  <= 1'b0;
            mult_op1 <= '0;
            mult_op2 <= '0;
        end else begin
            case (state)
                HILO_IDLE: begin
                    if (start) begin
                        // Magnitudes: the most negative value maps onto itself as unsigned.
                        mult_op1 <= (is_signed && op1[W-1]) ? -op1 : op1;
                        mult_op2 <= (is_signed && op2[W-1]) ? -op2 : op2;
                        neg      <= is_signed & (op1[W-1] ^ op2[W-1]);
                        mult_go  <= 1'b1;
                        state    <= HILO_RUN;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                HILO_RUN: begin
                    if (!mult_hold) begin
                        prod    <= mult_res;
                        mult_go <= 1'b0;
                        state   <= HILO_FIX;
                    end
                end
                HILO_FIX: begin
                    {hi, lo} <= neg ? -prod : prod;
                    state    <= HILO_IDLE;
                end
                default: state <= HILO_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit with a behavioural serial multiplier whose latency follows
// the bit length of its first operand; results flow through an expected-value queue.
module tb_hilo_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           is_signed = 1'b0;
    logic [W-1:0]   op1 = '0;
    logic [W-1:0]   op2 = '0;
    logic           mthi = 1'b0;
    logic           mtlo = 1'b0;
    logic [W-1:0]   wdata = '0;
    logic           rd_hi = 1'b0;
    logic           rd_lo = 1'b0;
    logic [W-1:0]   rdata;
    logic           stall;
    logic           busy;
    logic [W-1:0]   mult_op1;
    logic [W-1:0]   mult_op2;
    logic           mult_go;
    logic           mult_hold;
    logic [2*W-1:0] mult_res;

    hilo_unit #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .op1(op1), .op2(op2), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .rd_hi(rd_hi), .rd_lo(rd_lo), .rdata(rdata), .stall(stall), .busy(busy),
        .mult_op1(mult_op1), .mult_op2(mult_op2), .mult_go(mult_go),
        .mult_hold(mult_hold), .mult_res(mult_res)
    );

    always #5 clk = ~clk;

    // Serial multiplier model: hold stays high for bitlen(op1) cycles after go rises.
    logic [6:0] mcyc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               mcyc <= '0;
        else if (!mult_go)     mcyc <= '0;
        else if (mcyc != 7'd127) mcyc <= mcyc + 7'd1;
    end

    function automatic int bitlen(input logic [W-1:0] x);
        int n = 0;
        for (int i = 0; i < W; i++) if (x[i]) n = i + 1;
        return n;
    endfunction

    assign mult_hold = mult_go && (int'(mcyc) < bitlen(mult_op1));
    assign mult_res  = {{W{1'b0}}, mult_op1} * {{W{1'b0}}, mult_op2};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;
    res_t sb[$];

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [W-1:0] m1;
        logic [W-1:0] m2;
    } vec_t;
    vec_t tbl[6];

    task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
        rd_hi = 1'b1; rd_lo = 1'b0; #1; h = rdata;
        rd_hi = 1'b0; rd_lo = 1'b1; #1; l = rdata;
        rd_lo = 1'b0; #1;
    endtask

    // Waits (bounded) for busy to fall, counting negedges and auditing stall.
    task automatic wait_idle(input logic probe_rd, output int cycles);
        int stall_seen = 0;
        int stall_bad  = 0;
        cycles = 0;
        rd_lo = probe_rd;
        #1;
        while (busy && cycles < 200) begin
            if (stall !== (rd_lo | rd_hi | mthi | mtlo | start)) stall_bad++;
            if (stall) stall_seen++;
            @(negedge clk);
            cycles++;
            #1;
        end
        if (probe_rd) begin
            check("stall_while_busy_audit", 64'(stall_bad), 64'd0);
            check("stall_seen_on_mflo", 64'(stall_seen > 0), 64'd1);
            check("no_stall_in_idle", {63'd0, stall}, 64'd0);
        end
        rd_lo = 1'b0;
        if (cycles >= 200) check("busy_timeout", 64'd1, 64'd0);
    endtask

    // Caller must be at a negedge; start is presented immediately.
    task automatic run_mult(input string name, input logic sgn, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] ehi,
                            input logic [W-1:0] elo, input logic [W-1:0] em1,
                            input logic [W-1:0] em2, input logic check_ops,
                            input logic probe_rd, output int cycles);
        res_t r, e;
        logic [W-1:0] h, l;
        start = 1'b1; is_signed = sgn; op1 = a; op2 = b;
        r.hi = ehi; r.lo = elo;
        sb.push_back(r);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        #1;
        check({name, "_busy"}, {63'd0, busy}, 64'd1);
        if (check_ops) begin
            check({name, "_mult_op1"}, 64'(mult_op1), 64'(em1));
            check({name, "_mult_op2"}, 64'(mult_op2), 64'(em2));
        end
        wait_idle(probe_rd, cycles);
        e = sb.pop_front();
        read_hilo(h, l);
        check({name, "_hi"}, 64'(h), 64'(e.hi));
        check({name, "_lo"}, 64'(l), 64'(e.lo));
    endtask

    initial begin
        logic [W-1:0] h, l, a, b;
        logic [63:0]  p;
        logic         sgn;
        int           cyc;

        tbl[0] = '{1'b1, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 32'h3,        32'h5};
        tbl[1] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h80000000, 32'h80000000};
        tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[3] = '{1'b1, 32'h7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 32'h7,        32'h6};
        tbl[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h1,        32'h1};
        tbl[5] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 32'h00010000, 32'h00010000};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_go", {63'd0, mult_go}, 64'd0);
        check("reset_op1", 64'(mult_op1), 64'd0);
        read_hilo(h, l);
        check("reset_hi", 64'(h), 64'd0);
        check("reset_lo", 64'(l), 64'd0);
        @(negedge clk);

        // MULTU 7*6 with an MFLO waiting behind it
        run_mult("multu_7x6", 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 32'd7, 32'd6, 1'b1, 1'b1, cyc);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run_mult($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b,
                     tbl[i].hi, tbl[i].lo, tbl[i].m1, tbl[i].m2, 1'b1, 1'b0, cyc);
        end

        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
            if (sgn) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            else     p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            @(negedge clk);
            run_mult($sformatf("rnd%0d", i), sgn, a, b, p[63:32], p[31:0], '0, '0, 1'b0, 1'b0, cyc);
        end

        // Zero operand: product lands two edges after start, then an immediate re-issue
        @(negedge clk);
        run_mult("zero_op", 1'b0, 32'd0, 32'h1234, 32'h0, 32'h0, 32'd0, 32'h1234, 1'b1, 1'b0, cyc);
        check("zero_op_latency", 64'(cyc), 64'd2);
        check("go_low_in_idle", {63'd0, mult_go}, 64'd0);
        run_mult("back_to_back", 1'b0, 32'd2, 32'd3, 32'h0, 32'h6, 32'd2, 32'd3, 1'b1, 1'b0, cyc);

        // MTLO in IDLE with a same-cycle MFLO returning the old value
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'hCAFE; rd_lo = 1'b1; #1;
        check("mtlo_old_read", 64'(rdata), 64'h6);
        check("mtlo_no_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        mtlo = 1'b0; #1;
        check("mtlo_new_read", 64'(rdata), 64'hCAFE);
        rd_lo = 1'b0;
        mthi = 1'b1; wdata = 32'h5555;
        @(negedge clk);
        mthi = 1'b0; rd_hi = 1'b1; rd_lo = 1'b1; #1;
        check("rd_hi_priority", 64'(rdata), 64'h5555);
        rd_hi = 1'b0; rd_lo = 1'b0;

        // MTHI while busy is stalled and does not touch HI
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op1 = 32'hFF; op2 = 32'h100;
        sb.push_back('{32'h0, 32'hFF00});
        @(negedge clk);
        start = 1'b0; mthi = 1'b1; wdata = 32'hDEAD; #1;
        check("mthi_run_stall", {63'd0, stall}, 64'd1);
        @(negedge clk);
        mthi = 1'b0; rd_hi = 1'b1; #1;
        check("mthi_run_hi_kept", 64'(rdata), 64'h5555);
        rd_hi = 1'b0;
        wait_idle(1'b0, cyc);
        begin
            res_t e;
            e = sb.pop_front();
            read_hilo(h, l);
            check("mthi_run_final_hi", 64'(h), 64'(e.hi));
            check("mthi_run_final_lo", 64'(l), 64'(e.lo));
        end

        // start and MTLO together: the multiply wins
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'hBEEF;
        run_mult("start_beats_mtlo", 1'b0, 32'd3, 32'd3, 32'h0, 32'h9, 32'd3, 32'd3, 1'b1, 1'b0, cyc);

        // Reset during a long RUN
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op1 = 32'hFFFFFFFF; op2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_go", {63'd0, mult_go}, 64'd1);
        rst = 1'b1; #1;
        check("rst_go", {63'd0, mult_go}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        read_hilo(h, l);
        check("rst_hi", 64'(h), 64'd0);
        check("rst_lo", 64'(l), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_mult("post_rst", 1'b1, 32'hFFFFFFFE, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'd2, 32'd4, 1'b1, 1'b0, cyc);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
